// File: rtl/rx_ibuf_wr_pkg.sv
// Shared types and header layout for the RX internal buffer write side.
// Optional feature macro used by rx_ibuf_wr: RX_IBUF_STATS_EN.
package rx_ibuf_wr_pkg;

  // FSM states for the write controller.
  // ST_DROP_DONE finishes a bad single-beat frame.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_COMMIT,
    ST_DROP,
    ST_DROP_DONE
  } state_t;

  // Header word field layout.
  localparam int HDR_LEN_LSB  = 0;
  localparam int HDR_LEN_W    = 16;
  localparam int HDR_WCNT_LSB = 16;
  localparam int HDR_WCNT_W   = 8;

  // Build the 64-bit frame header word. Unused upper bits are zero.
  function automatic logic [63:0] make_hdr(input logic [HDR_LEN_W-1:0]  len,
                                           input logic [HDR_WCNT_W-1:0] wcnt);
    logic [63:0] h;
    h = '0;
    h[HDR_LEN_LSB  +: HDR_LEN_W]  = len;
    h[HDR_WCNT_LSB +: HDR_WCNT_W] = wcnt;
    return h;
  endfunction

endpackage

// File: rtl/rx_ibuf_wr_if.sv
// MAC RX beat stream into the RX buffer write controller.
// The MAC cannot stall, so the stream has no ready signal.
interface rx_ibuf_wr_if #(
  parameter int DW = 64
);
  logic [DW-1:0]   data;   // byte 0 = bits [7:0]
  logic [DW/8-1:0] keep;   // contiguous from bit 0 on the last beat
  logic            valid;
  logic            last;
  logic            bad;    // qualifies last: FCS/PHY error

  modport master (output data, keep, valid, last, bad);
  modport slave  (input  data, keep, valid, last, bad);
endinterface

// File: rtl/rx_ibuf_keep2cnt.sv
// Byte-valid mask to byte count (1..KW for a legal last-beat mask).
module rx_ibuf_keep2cnt #(
  parameter  int KW = 8,
  localparam int CW = $clog2(KW + 1)
) (
  input  logic [KW-1:0] keep,
  output logic [CW-1:0] cnt
);

  // Population count of the keep mask.
  // NOTE: cnt gets a default before the loop so every path assigns it and no latch is inferred.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < KW; i++) begin
      cnt = cnt + CW'(keep[i]);
    end
  end

endmodule

// File: rtl/rx_ibuf_wr.sv
// RX internal buffer write-side controller.
// Writes each frame as a header word followed by its data words into the
// RX DPRAM, drops bad/oversized/overflowing frames, and publishes a commit
// pointer two cycles after the header write.
// Optional macro RX_IBUF_STATS_EN adds saturating commit/drop counters.
module rx_ibuf_wr
  import rx_ibuf_wr_pkg::*;
#(
  parameter int AW        = 9,
  parameter int DW        = 64,
  parameter int MAX_WORDS = 190
) (
  input  logic          clk,
  input  logic          reset_n,
  rx_ibuf_wr_if.slave   rx,
  input  logic [AW-1:0] rd_ptr,
  output logic [AW-1:0] wr_a,
  output logic [DW-1:0] wr_d,
  output logic          wr_en,
  output logic [AW-1:0] commit_ptr,
  output logic          frame_commit,
  output logic          frame_drop
`ifdef RX_IBUF_STATS_EN
  ,
  output logic [31:0]   stat_commit,
  output logic [31:0]   stat_drop_bad,
  output logic [31:0]   stat_drop_ovf
`endif
);

  localparam int KW  = DW / 8;
  localparam int CW  = $clog2(KW + 1);
  localparam int WCW = $clog2(MAX_WORDS + 1);

  state_t                 state;
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          hdr_ptr;
  logic [AW-1:0]          commit_tgt;
  logic [AW-1:0]          free;
  logic [WCW-1:0]         wcnt;
  logic [CW-1:0]          keep_cnt;
  logic [CW-1:0]          last_cnt;
  logic [1:0]             commit_pipe;
  logic                   ovf_hit;
  logic                   drop_bad_set;
  logic                   drop_ovf_set;
  logic [HDR_LEN_W-1:0]   frame_len;

  rx_ibuf_keep2cnt #(.KW(KW)) u_keep2cnt (
    .keep (rx.keep),
    .cnt  (keep_cnt)
  );

  // Free space, overflow test, header length and drop classification.
  always_comb begin
    free         = rd_ptr - wr_ptr - AW'(1);
    ovf_hit      = (free == '0) || (wcnt == WCW'(MAX_WORDS));
    frame_len    = HDR_LEN_W'({wcnt - WCW'(1), 3'b000}) + HDR_LEN_W'(last_cnt);
    drop_ovf_set = 1'b0;
    drop_bad_set = 1'b0;
    case (state)
      ST_IDLE:      drop_ovf_set = rx.valid && rx.last && (free < AW'(2));
      ST_RECV: begin
        drop_ovf_set = rx.valid && rx.last && ovf_hit;
        drop_bad_set = rx.valid && rx.last && !ovf_hit && rx.bad;
      end
      // A beat during COMMIT breaks the inter-frame gap and is dropped.
      ST_COMMIT,
      ST_DROP:      drop_ovf_set = rx.valid && rx.last;
      ST_DROP_DONE: drop_bad_set = 1'b1;
      default: ;
    endcase
  end

  // Frame FSM, write port, pointers and registered pulses.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: all registers, data path included, are reset so every output reads 0 after reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      wr_ptr       <= '0;
      hdr_ptr      <= '0;
      commit_tgt   <= '0;
      commit_ptr   <= '0;
      wcnt         <= '0;
      last_cnt     <= '0;
      commit_pipe  <= '0;
      wr_a         <= '0;
      wr_d         <= '0;
      wr_en        <= 1'b0;
      frame_commit <= 1'b0;
      frame_drop   <= 1'b0;
    end else begin
      wr_en        <= 1'b0;
      frame_drop   <= drop_ovf_set | drop_bad_set;
      // Commit trails the header write by two cycles to cover the RAM input register.
      commit_pipe  <= {commit_pipe[0], state == ST_COMMIT};
      frame_commit <= commit_pipe[1];
      if (commit_pipe[1]) commit_ptr <= commit_tgt;

      case (state)
        ST_IDLE: begin
          if (rx.valid) begin
            if (free >= AW'(2)) begin
              // Reserve the header slot; first beat goes right after it.
              hdr_ptr  <= wr_ptr;
              wr_a     <= wr_ptr + AW'(1);
              wr_d     <= rx.data;
              wr_en    <= 1'b1;
              wr_ptr   <= wr_ptr + AW'(2);
              wcnt     <= WCW'(1);
              last_cnt <= keep_cnt;
              if (rx.last) state <= rx.bad ? ST_DROP_DONE : ST_COMMIT;
              else         state <= ST_RECV;
            end else if (!rx.last) begin
              state <= ST_DROP;
            end
          end
        end

        ST_RECV: begin
          if (rx.valid) begin
            if (ovf_hit) begin
              wr_ptr <= hdr_ptr;
              state  <= rx.last ? ST_IDLE : ST_DROP;
            end else begin
              wr_a     <= wr_ptr;
              wr_d     <= rx.data;
              wr_en    <= 1'b1;
              wr_ptr   <= wr_ptr + AW'(1);
              wcnt     <= wcnt + WCW'(1);
              last_cnt <= keep_cnt;
              if (rx.last) begin
                if (rx.bad) begin
                  wr_ptr <= hdr_ptr;
                  state  <= ST_IDLE;
                end else begin
                  state  <= ST_COMMIT;
                end
              end
            end
          end
        end

        ST_COMMIT: begin
          // Header last, so the consumer never sees a partial frame.
          wr_a       <= hdr_ptr;
          wr_d       <= DW'(make_hdr(frame_len, HDR_WCNT_W'(wcnt)));
          wr_en      <= 1'b1;
          commit_tgt <= wr_ptr;
          state      <= (rx.valid && !rx.last) ? ST_DROP : ST_IDLE;
        end

        ST_DROP_DONE: begin
          wr_ptr <= hdr_ptr;
          state  <= (rx.valid && !rx.last) ? ST_DROP : ST_IDLE;
        end

        ST_DROP: begin
          if (rx.valid && rx.last) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef RX_IBUF_STATS_EN
  // Saturating event counters, stepped on the same edge that raises each pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_commit   <= '0;
      stat_drop_bad <= '0;
      stat_drop_ovf <= '0;
    end else begin
      if (commit_pipe[1] && (stat_commit != '1))   stat_commit   <= stat_commit + 32'd1;
      if (drop_bad_set   && (stat_drop_bad != '1)) stat_drop_bad <= stat_drop_bad + 32'd1;
      if (drop_ovf_set   && (stat_drop_ovf != '1)) stat_drop_ovf <= stat_drop_ovf + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rx_ibuf_wr.sv
// Self-checking bench for rx_ibuf_wr (AW=9, DW=64, MAX_WORDS=190).
module tb_rx_ibuf_wr;

  localparam int AW = 9;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_a;
  logic [DW-1:0] wr_d;
  logic          wr_en;
  logic [AW-1:0] commit_ptr;
  logic          frame_commit;
  logic          frame_drop;
`ifdef RX_IBUF_STATS_EN
  logic [31:0]   stat_commit;
  logic [31:0]   stat_drop_bad;
  logic [31:0]   stat_drop_ovf;
`endif

  rx_ibuf_wr_if #(.DW(DW)) rx_if ();

  rx_ibuf_wr #(.AW(AW), .DW(DW), .MAX_WORDS(190)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx           (rx_if),
    .rd_ptr       (rd_ptr),
    .wr_a         (wr_a),
    .wr_d         (wr_d),
    .wr_en        (wr_en),
    .commit_ptr   (commit_ptr),
    .frame_commit (frame_commit),
    .frame_drop   (frame_drop)
`ifdef RX_IBUF_STATS_EN
    ,
    .stat_commit   (stat_commit),
    .stat_drop_bad (stat_drop_bad),
    .stat_drop_ovf (stat_drop_ovf)
`endif
  );

  always #5 clk = ~clk;

  // RAM model and pulse counters, sampled mid-cycle.
  logic [DW-1:0] mem [2**AW];
  int n_wr, n_commit, n_drop;
  int n_checks = 0;
  int n_fail   = 0;

  always @(negedge clk) begin
    if (wr_en) begin
      mem[wr_a] = wr_d;
      n_wr++;
    end
    if (frame_commit) n_commit++;
    if (frame_drop)   n_drop++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] beat_word(input logic [15:0] tag, input int i);
    return {16'hA5A5, tag, 32'(i)};
  endfunction

  function automatic logic [63:0] hdr_word(input logic [15:0] len, input logic [7:0] wcnt);
    return {40'h0, wcnt, len};
  endfunction

  task automatic clear_counts();
    n_wr = 0; n_commit = 0; n_drop = 0;
  endtask

  // One beat per cycle, then idle long enough for the commit pipeline to drain.
  task automatic send_frame(input int nbeats, input logic [7:0] last_keep,
                            input bit is_bad, input logic [15:0] tag);
    for (int i = 1; i <= nbeats; i++) begin
      @(posedge clk); #1;
      rx_if.valid = 1'b1;
      rx_if.data  = beat_word(tag, i);
      rx_if.keep  = (i == nbeats) ? last_keep : 8'hFF;
      rx_if.last  = (i == nbeats);
      rx_if.bad   = (i == nbeats) && is_bad;
    end
    @(posedge clk); #1;
    rx_if.valid = 1'b0; rx_if.last = 1'b0; rx_if.bad = 1'b0; rx_if.keep = '0; rx_if.data = '0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  typedef struct {
    int            nbeats;
    logic [7:0]    keep;
    bit            bad;
    logic [AW-1:0] exp_commit;
    logic [AW-1:0] exp_hdr;
    logic [15:0]   exp_len;
    logic [7:0]    exp_wcnt;
  } vec_t;

  vec_t vecs [6];
  logic [AW-1:0] exp_cp;
  logic [AW-1:0] a;

  initial begin
    // Back-to-back frames from address 0 with rd_ptr=0 (plenty of space).
    vecs[0] = '{8, 8'h0F, 1'b0, 9'd9,  9'd0,  16'd60, 8'd8};
    vecs[1] = '{1, 8'h01, 1'b0, 9'd11, 9'd9,  16'd1,  8'd1};
    vecs[2] = '{3, 8'hFF, 1'b1, 9'd11, 9'd0,  16'd0,  8'd0};
    vecs[3] = '{2, 8'h07, 1'b0, 9'd14, 9'd11, 16'd11, 8'd2};  // reuses dropped frame's hdr_ptr
    vecs[4] = '{1, 8'h01, 1'b1, 9'd14, 9'd0,  16'd0,  8'd0};
    vecs[5] = '{5, 8'h3F, 1'b0, 9'd20, 9'd14, 16'd38, 8'd5};

    for (int i = 0; i < 2**AW; i++) mem[i] = '0;
    reset_n = 1'b0; rd_ptr = '0;
    rx_if.valid = 1'b0; rx_if.last = 1'b0; rx_if.bad = 1'b0; rx_if.keep = '0; rx_if.data = '0;
    clear_counts();
    repeat (3) @(posedge clk);
    #1;
    check("reset wr_en",        64'(wr_en),        64'd0);
    check("reset wr_a",         64'(wr_a),         64'd0);
    check("reset wr_d",         wr_d,              64'd0);
    check("reset commit_ptr",   64'(commit_ptr),   64'd0);
    check("reset frame_commit", 64'(frame_commit), 64'd0);
    check("reset frame_drop",   64'(frame_drop),   64'd0);
    reset_n = 1'b1;

    // Table-driven frames.
    for (int v = 0; v < 6; v++) begin
      clear_counts();
      send_frame(vecs[v].nbeats, vecs[v].keep, vecs[v].bad, 16'(v + 1));
      check($sformatf("v%0d commit_ptr", v), 64'(commit_ptr), 64'(vecs[v].exp_commit));
      check($sformatf("v%0d commits", v), 64'(n_commit), vecs[v].bad ? 64'd0 : 64'd1);
      check($sformatf("v%0d drops", v),   64'(n_drop),   vecs[v].bad ? 64'd1 : 64'd0);
      check($sformatf("v%0d writes", v),  64'(n_wr),
            64'(vecs[v].nbeats + (vecs[v].bad ? 0 : 1)));
      if (!vecs[v].bad) begin
        a = vecs[v].exp_hdr;
        check($sformatf("v%0d header", v), mem[a], hdr_word(vecs[v].exp_len, vecs[v].exp_wcnt));
        a = vecs[v].exp_hdr + 9'd1;
        check($sformatf("v%0d first data", v), mem[a], beat_word(16'(v + 1), 1));
        a = vecs[v].exp_hdr + 9'(vecs[v].nbeats);
        check($sformatf("v%0d last data", v), mem[a], beat_word(16'(v + 1), vecs[v].nbeats));
      end
    end

    // Advance to commit_ptr=500 with the consumer draining behind.
    exp_cp = 9'd20;
    for (int k = 0; k < 3; k++) begin
      rd_ptr = exp_cp;
      send_frame(159, 8'hFF, 1'b0, 16'h0020 + 16'(k));
      exp_cp = exp_cp + 9'd160;
      check($sformatf("fill%0d commit_ptr", k), 64'(commit_ptr), 64'(exp_cp));
    end

    // rd_ptr=0, wr_ptr=500: 10 data words fit, the 11th beat overflows.
    rd_ptr = '0;
    clear_counts();
    send_frame(20, 8'hFF, 1'b0, 16'h0030);
    check("ovf drops",      64'(n_drop),     64'd1);
    check("ovf commits",    64'(n_commit),   64'd0);
    check("ovf writes",     64'(n_wr),       64'd10);
    check("ovf commit_ptr", 64'(commit_ptr), 64'd500);

    // Consumer frees space: frame rewinds to 500 and wraps past 511.
    rd_ptr = 9'd100;
    clear_counts();
    send_frame(20, 8'hFF, 1'b0, 16'h0031);
    check("wrap commit_ptr", 64'(commit_ptr), 64'd9);
    check("wrap commits",    64'(n_commit),   64'd1);
    check("wrap writes",     64'(n_wr),       64'd21);
    check("wrap header",     mem[500],        hdr_word(16'd160, 8'd20));
    check("wrap data 1",     mem[501],        beat_word(16'h0031, 1));
    check("wrap data 11",    mem[511],        beat_word(16'h0031, 11));
    check("wrap data 12",    mem[0],          beat_word(16'h0031, 12));
    check("wrap data 20",    mem[8],          beat_word(16'h0031, 20));

    // Oversize: 190 data words accepted, beat 191 drops the frame.
    rd_ptr = 9'd9;
    clear_counts();
    send_frame(200, 8'hFF, 1'b0, 16'h0040);
    check("big drops",      64'(n_drop),     64'd1);
    check("big commits",    64'(n_commit),   64'd0);
    check("big writes",     64'(n_wr),       64'd190);
    check("big commit_ptr", 64'(commit_ptr), 64'd9);

    // Recovery after oversize drop.
    clear_counts();
    send_frame(4, 8'hFF, 1'b0, 16'h0041);
    check("rec commit_ptr", 64'(commit_ptr), 64'd14);
    check("rec header",     mem[9],          hdr_word(16'd32, 8'd4));

`ifdef RX_IBUF_STATS_EN
    check("stat_commit",   64'(stat_commit),   64'd9);
    check("stat_drop_bad", 64'(stat_drop_bad), 64'd2);
    check("stat_drop_ovf", 64'(stat_drop_ovf), 64'd2);
`endif

    // Reset in the middle of RECV.
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      rx_if.valid = 1'b1; rx_if.data = beat_word(16'h0050, i);
      rx_if.keep = 8'hFF; rx_if.last = 1'b0; rx_if.bad = 1'b0;
    end
    @(posedge clk); #1;
    rx_if.valid = 1'b0; rx_if.data = '0; rx_if.keep = '0;
    reset_n = 1'b0; rd_ptr = '0;
    @(posedge clk); #1;
    check("mid-rst wr_en",        64'(wr_en),        64'd0);
    check("mid-rst wr_a",         64'(wr_a),         64'd0);
    check("mid-rst wr_d",         wr_d,              64'd0);
    check("mid-rst commit_ptr",   64'(commit_ptr),   64'd0);
    check("mid-rst frame_commit", 64'(frame_commit), 64'd0);
    check("mid-rst frame_drop",   64'(frame_drop),   64'd0);
`ifdef RX_IBUF_STATS_EN
    check("mid-rst stat_commit",  64'(stat_commit),  64'd0);
`endif
    reset_n = 1'b1;

    // Single-beat frame from address 0 after reset.
    clear_counts();
    send_frame(1, 8'h01, 1'b0, 16'h0060);
    check("post-rst commit_ptr", 64'(commit_ptr), 64'd2);
    check("post-rst commits",    64'(n_commit),   64'd1);
    check("post-rst header",     mem[0],          hdr_word(16'd1, 8'd1));
    check("post-rst data",       mem[1],          beat_word(16'h0060, 1));
`ifdef RX_IBUF_STATS_EN
    check("post-rst stat_commit", 64'(stat_commit), 64'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
